// File: rtl/pe_stream_packer.sv
// pe_stream_packer
// Packs PACK = OUT_WIDTH/IN_WIDTH consecutive narrow pixels into one wide word.
// Lane 0 holds the first pixel.
// Each word is pushed into a PE input FIFO, and the push is held off while the FIFO is full.
// A transfer of `count` pixels ends with a one-cycle done pulse.
// A short tail word is zero-padded above its last pixel.
module pe_stream_packer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 done,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 push,
    input  logic                 fifo_full
);
    localparam int PACK  = OUT_WIDTH / IN_WIDTH;
    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PACK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [OUT_WIDTH-1:0] pack_reg, pack_next;
    logic [OUT_WIDTH-1:0] fill_word;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [CNT_WIDTH-1:0] remaining_reg, remaining_next;

    // fill_word is the pack register with the incoming pixel merged into lane idx.
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            assign fill_word[gi*IN_WIDTH +: IN_WIDTH] =
                (idx_reg == IDX_W'(gi)) ? in_data : pack_reg[gi*IN_WIDTH +: IN_WIDTH];
        end
        if (PACK * IN_WIDTH < OUT_WIDTH) begin : g_pad
            assign fill_word[OUT_WIDTH-1:PACK*IN_WIDTH] = '0;
        end
    endgenerate

    // Outputs decode straight from the state.
    // push is additionally gated by reset, so an aborted word never reaches the FIFO.
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign in_ready = (state_reg == FILL);
    assign push     = (state_reg == PUSH) && !fifo_full && !reset;
    assign out_data = pack_reg;

    // Next-state and datapath update for the IDLE/FILL/PUSH/DONE sequence.
    always_comb begin
        state_next     = state_reg;
        pack_next      = pack_reg;
        idx_next       = idx_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        remaining_next = count;
                        pack_next      = '0;
                        idx_next       = '0;
                        state_next     = FILL;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    pack_next      = fill_word;
                    idx_next       = idx_reg + IDX_W'(1);
                    remaining_next = remaining_reg - CNT_WIDTH'(1);
                    if (idx_reg == LAST_LANE || remaining_reg == CNT_WIDTH'(1)) begin
                        state_next = PUSH;
                    end
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    // Clearing after every push leaves out_data at zero once idle again.
                    pack_next  = '0;
                    idx_next   = '0;
                    state_next = (remaining_reg == '0) ? DONE : FILL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pack_reg      <= '0;
            idx_reg       <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pack_reg      <= pack_next;
            idx_reg       <= idx_next;
            remaining_reg <= remaining_next;
        end
    end
endmodule

// File: tb/tb_pe_stream_packer.sv
// Testbench for pe_stream_packer.
// Expected words are queued when stimulus is issued.
// A negedge monitor pops and compares them on every push.
module tb_pe_stream_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        busy, done, in_ready, push;
    logic [63:0] out_data;

    int tests = 0;
    int fails = 0;
    int push_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [63:0] exp_q[$];

    pe_stream_packer #(.IN_WIDTH(16), .OUT_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .push(push), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: every push must match the oldest queued word.
    always @(negedge clk) begin
        if (push) begin
            push_cnt++;
            if (fifo_full) check("push_while_full", 64'd1, 64'd0);
            if (exp_q.size() == 0) check("unexpected_push", out_data, 64'd0);
            else check("push_word", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called one step after a posedge; start is sampled at the next edge.
    task automatic start_xfer(input logic [15:0] n);
        start = 1'b1;
        count = n;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    // Offers one pixel and returns one step after the edge that accepts it.
    task automatic send(input logic [15:0] px);
        bit ok = 0;
        in_data  = px;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    // lat = edges from the start-sampling edge to the DONE cycle.
    task automatic wait_done(input int lat);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("done_latency", 64'(cyc - start_cyc), 64'(lat));
                check("busy_at_done", {63'd0, busy}, 64'd1);
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            check("done_fall", {63'd0, done}, 64'd0);
            check("busy_fall", {63'd0, busy}, 64'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_push"}, {63'd0, push}, 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
    endtask

    int base;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // count=8, continuous stream: two full words; DONE in cycle t+11.
        base = push_cnt;
        exp_q.push_back(64'h0004_0003_0002_0001);
        exp_q.push_back(64'h0008_0007_0006_0005);
        start_xfer(16'd8);
        for (int i = 1; i <= 8; i++) send(16'(i));
        in_valid = 1'b0;
        wait_done(10);
        check("t1_pushes", 64'(push_cnt - base), 64'd2);

        // count=6: the second word is a zero-padded tail.
        base = push_cnt;
        exp_q.push_back(64'h00A4_00A3_00A2_00A1);
        exp_q.push_back(64'h0000_0000_00A6_00A5);
        start_xfer(16'd6);
        for (int i = 1; i <= 6; i++) send(16'h00A0 + 16'(i));
        in_valid = 1'b0;
        wait_done(8);
        check("t2_pushes", 64'(push_cnt - base), 64'd2);

        // count=4 with fifo_full held for 5 PUSH cycles.
        base = push_cnt;
        fifo_full = 1'b1;
        exp_q.push_back(64'h00C4_00C3_00C2_00C1);
        start_xfer(16'd4);
        for (int i = 1; i <= 4; i++) send(16'h00C0 + 16'(i));
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_push_low", {63'd0, push}, 64'd0);
            check("bp_hold", out_data, 64'h00C4_00C3_00C2_00C1);
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_release_push", {63'd0, push}, 64'd1);
        wait_done(10);
        check("t3_pushes", 64'(push_cnt - base), 64'd1);

        // count=0: no push; DONE in the cycle right after start.
        base = push_cnt;
        start_xfer(16'd0);
        wait_done(0);
        check("t4_pushes", 64'(push_cnt - base), 64'd0);

        // Alternating in_valid plus an ignored second start mid-transfer.
        base = push_cnt;
        exp_q.push_back(64'h00D4_00D3_00D2_00D1);
        start_xfer(16'd4);
        for (int i = 1; i <= 4; i++) begin
            send(16'h00D0 + 16'(i));
            in_valid = 1'b0;
            if (i < 4) begin
                if (i == 2) begin
                    start = 1'b1;
                    count = 16'd9;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done(8);
        check("t5_pushes", 64'(push_cnt - base), 64'd1);

        // Reset after 2 of 4 pixels; then a clean transfer.
        base = push_cnt;
        start_xfer(16'd4);
        send(16'h00F1);
        send(16'h00F2);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk); #1;
        check("abort_pushes", 64'(push_cnt - base), 64'd0);
        exp_q.push_back(64'h00E4_00E3_00E2_00E1);
        start_xfer(16'd4);
        for (int i = 1; i <= 4; i++) send(16'h00E0 + 16'(i));
        in_valid = 1'b0;
        wait_done(5);
        check("t6_pushes", 64'(push_cnt - base), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("total_pushes", 64'(push_cnt), 64'd7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
